// File: rtl/train_phase_scheduler.sv
// Multi-layer training sequencer: issues FP requests per layer, then BP/WG in
// reverse layer order, per iteration. Drives the output-buffer bank select and
// guards every WAIT phase with a watchdog.
module train_phase_scheduler #(
  parameter int unsigned MAX_LAYERS = 8,
  parameter int unsigned LW         = 3,
  parameter int unsigned ITER_W     = 4,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned TW         = 8
) (
  input  logic              clk,
  input  logic              sched_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [LW-1:0]     num_layers_m1,
  input  logic [ITER_W-1:0] iterations_m1,
  input  logic              cfg_we,
  input  logic [LW-1:0]     cfg_addr,
  input  logic              cfg_stride,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [1:0]        req_phase,
  output logic [LW-1:0]     req_layer,
  output logic              req_stride,
  input  logic              phase_done,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              buf_bank,
  output logic [ITER_W-1:0] iter_cnt
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FP_ISSUE = 4'd1;
  localparam logic [3:0] S_FP_WAIT  = 4'd2;
  localparam logic [3:0] S_BP_ISSUE = 4'd3;
  localparam logic [3:0] S_BP_WAIT  = 4'd4;
  localparam logic [3:0] S_WG_ISSUE = 4'd5;
  localparam logic [3:0] S_WG_WAIT  = 4'd6;
  localparam logic [3:0] S_DONE     = 4'd7;
  localparam logic [3:0] S_ERR      = 4'd8;

  localparam logic [1:0] PH_FP = 2'b01;
  localparam logic [1:0] PH_BP = 2'b10;
  localparam logic [1:0] PH_WG = 2'b11;

  localparam logic [TW-1:0] WDOG_LAST = TW'(TIMEOUT - 1);

  logic [3:0]            state_q, state_d;
  logic [LW-1:0]         layer_q, layer_d;
  logic [LW-1:0]         nl_q, nl_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic [ITER_W-1:0]     itm1_q, itm1_d;
  logic [TW-1:0]         wdog_q, wdog_d;
  logic                  bank_q, bank_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  req_valid_q, req_valid_d;
  logic [1:0]            req_phase_q, req_phase_d;
  logic [LW-1:0]         req_layer_q, req_layer_d;
  logic                  req_stride_q, req_stride_d;
  logic                  req_load;
  logic [MAX_LAYERS-1:0] stride_q;

  // Stride file: writable only while no sequence is running
  always_ff @(posedge clk or negedge sched_rst_n) begin
    if (!sched_rst_n) begin
      stride_q <= '0;
    end else if (cfg_we && !busy_q) begin
      for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
        if (cfg_addr == LW'(i)) stride_q[i] <= cfg_stride;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    nl_d         = nl_q;
    iter_d       = iter_q;
    itm1_d       = itm1_q;
    wdog_d       = wdog_q;
    bank_d       = bank_q;
    err_d        = err_q;
    done_d       = 1'b0;
    req_valid_d  = req_valid_q;
    req_phase_d  = req_phase_q;
    req_layer_d  = req_layer_q;
    req_stride_d = req_stride_q;
    req_load     = 1'b0;
    busy_d       = 1'b0;

    if (abort) begin
      state_d      = S_IDLE;
      layer_d      = '0;
      iter_d       = '0;
      wdog_d       = '0;
      bank_d       = 1'b0;
      err_d        = 1'b0;
      req_valid_d  = 1'b0;
      req_phase_d  = '0;
      req_layer_d  = '0;
      req_stride_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (state_q == S_DONE) state_d = S_IDLE;
          if (start) begin
            nl_d        = num_layers_m1;
            itm1_d      = iterations_m1;
            layer_d     = '0;
            iter_d      = '0;
            err_d       = 1'b0;
            bank_d      = 1'b0;
            wdog_d      = '0;
            state_d     = S_FP_ISSUE;
            req_valid_d = 1'b1;
            req_phase_d = PH_FP;
            req_layer_d = '0;
            req_load    = 1'b1;
          end
        end
        S_FP_ISSUE, S_BP_ISSUE, S_WG_ISSUE: begin
          if (req_ready) begin
            wdog_d      = '0;
            req_valid_d = 1'b0;
            case (state_q)
              S_FP_ISSUE: state_d = S_FP_WAIT;
              S_BP_ISSUE: state_d = S_BP_WAIT;
              default:    state_d = S_WG_WAIT;
            endcase
          end
        end
        S_FP_WAIT, S_BP_WAIT, S_WG_WAIT: begin
          if (phase_done) begin
            bank_d      = ~bank_q;
            wdog_d      = '0;
            req_valid_d = 1'b1;
            req_load    = 1'b1;
            case (state_q)
              S_FP_WAIT: begin
                if (layer_q == nl_q) begin
                  state_d     = S_BP_ISSUE;
                  req_phase_d = PH_BP;
                end else begin
                  layer_d     = layer_q + LW'(1);
                  state_d     = S_FP_ISSUE;
                  req_phase_d = PH_FP;
                end
              end
              S_BP_WAIT: begin
                state_d     = S_WG_ISSUE;
                req_phase_d = PH_WG;
              end
              default: begin
                if (layer_q != '0) begin
                  layer_d     = layer_q - LW'(1);
                  state_d     = S_BP_ISSUE;
                  req_phase_d = PH_BP;
                end else if (iter_q == itm1_q) begin
                  state_d     = S_DONE;
                  done_d      = 1'b1;
                  req_valid_d = 1'b0;
                  req_load    = 1'b0;
                end else begin
                  iter_d      = iter_q + ITER_W'(1);
                  layer_d     = '0;
                  state_d     = S_FP_ISSUE;
                  req_phase_d = PH_FP;
                end
              end
            endcase
            req_layer_d = layer_d;
          end else if (wdog_q == WDOG_LAST) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            wdog_d = wdog_q + TW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Stride is sampled from the file only when a new request is loaded
    if (req_load) begin
      req_stride_d = 1'b0;
      for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
        if (req_layer_d == LW'(i)) req_stride_d = stride_q[i];
      end
    end

    busy_d = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR));
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge sched_rst_n) begin
    if (!sched_rst_n) begin
      state_q      <= S_IDLE;
      layer_q      <= '0;
      nl_q         <= '0;
      iter_q       <= '0;
      itm1_q       <= '0;
      wdog_q       <= '0;
      bank_q       <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      req_phase_q  <= '0;
      req_layer_q  <= '0;
      req_stride_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      nl_q         <= nl_d;
      iter_q       <= iter_d;
      itm1_q       <= itm1_d;
      wdog_q       <= wdog_d;
      bank_q       <= bank_d;
      err_q        <= err_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      req_valid_q  <= req_valid_d;
      req_phase_q  <= req_phase_d;
      req_layer_q  <= req_layer_d;
      req_stride_q <= req_stride_d;
    end
  end

  assign req_valid  = req_valid_q;
  assign req_phase  = req_phase_q;
  assign req_layer  = req_layer_q;
  assign req_stride = req_stride_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign buf_bank   = bank_q;
  assign iter_cnt   = iter_q;

endmodule
